// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin front end for a shared 6-function bitwise logic unit.
// One op in flight at a time: IDLE accepts, EXEC computes, DONE holds the result until taken.

module logic_op_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        case (op)
            3'd0:    y =   a & b;
            3'd1:    y = ~(a & b);
            3'd2:    y =   a | b;
            3'd3:    y = ~(a | b);
            3'd4:    y =   a ^ b;
            3'd5:    y = ~(a ^ b);
            default: y = 1'b0;
        endcase
    end
endmodule

module logic_op_unit #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);
    // Illegal opcodes decode to 0 in every lane, so y is already forced low.
    assign err = (op > 3'd5);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_op_lane u_lane (
            .op (op),
            .a  (a[i]),
            .b  (b[i]),
            .y  (y[i])
        );
    end
endmodule

module logic_op_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state, state_nxt;
    logic             last_id;
    logic             grant_id;
    logic             any_vld;
    logic             accept;
    logic             res_load;
    logic             res_clear;
    req_t             req0, req1, cap;
    logic             cap_id;
    logic [WIDTH-1:0] unit_y;
    logic             unit_err;

    assign req0 = '{op: req0_op, a: req0_a, b: req0_b};
    assign req1 = '{op: req1_op, a: req1_a, b: req1_b};

    // On a tie the requester not served last wins.
    always_comb begin
        any_vld  = req0_valid | req1_valid;
        grant_id = 1'b0;
        if (req0_valid && req1_valid) grant_id = ~last_id;
        else if (req1_valid)          grant_id = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        res_load  = 1'b0;
        res_clear = 1'b0;
        case (state)
            IDLE: if (any_vld) begin
                accept    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                res_load  = 1'b1;
                state_nxt = DONE;
            end
            DONE: if (res_ready) begin
                res_clear = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept &  grant_id;
    assign busy       = (state != IDLE);

    logic_op_unit #(.WIDTH(WIDTH)) u_unit (
        .op  (cap.op),
        .a   (cap.a),
        .b   (cap.b),
        .y   (unit_y),
        .err (unit_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_id   <= 1'b1;
            cap       <= '0;
            cap_id    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            res_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cap     <= grant_id ? req1 : req0;
                cap_id  <= grant_id;
                last_id <= grant_id;
            end
            if (res_load) begin
                res_valid <= 1'b1;
                res_data  <= unit_y;
                res_id    <= cap_id;
                res_err   <= unit_err;
            end
            if (res_clear) res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: vector table plus hand-written sequences, results checked via a scoreboard queue.

module tb_logic_op_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_ready, res_id, res_err, busy;
    logic [7:0] res_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       id;
        logic       err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ed;
        logic       ee;
    } vec_t;

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_err(res_err), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            3'd0: e.data = a & b;
            3'd1: e.data = ~(a & b);
            3'd2: e.data = a | b;
            3'd3: e.data = ~(a | b);
            3'd4: e.data = a ^ b;
            3'd5: e.data = ~(a ^ b);
            default: begin e.data = 8'h00; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Monitor: protocol sanity every cycle, scoreboard pop on each result transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("ready_without_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 0);
            chk("both_ready", req0_ready & req1_ready, 0);
            if (res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: data=%0h id=%0d with empty scoreboard", res_data, res_id);
                end else begin
                    e = sbq.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_id", res_id, e.id);
                    chk("res_err", res_err, e.err);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        logic got = 1'b0;
        @(posedge clk); #1;
        if (v.id) begin req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
        else      begin req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (v.id ? req1_ready : req0_ready) begin
                got = 1'b1;
                sbq.push_back('{v.ed, v.id, v.ee});
            end
        end
        chk("accept", got, 1);
        @(posedge clk); #1;
        // Scramble operands after the accept edge; the in-flight result must not change.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (sbq.size() == 0) && !busy, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        int   grants, cyc, last_cyc;
        logic gid;
        logic seen;

        vecs[0] = '{1'b0, 3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
        vecs[1] = '{1'b0, 3'd1, 8'hA5, 8'h0F, 8'hFA, 1'b0};
        vecs[2] = '{1'b0, 3'd2, 8'hA5, 8'h0F, 8'hAF, 1'b0};
        vecs[3] = '{1'b0, 3'd3, 8'hA5, 8'h0F, 8'h50, 1'b0};
        vecs[4] = '{1'b0, 3'd4, 8'hA5, 8'h0F, 8'hAA, 1'b0};
        vecs[5] = '{1'b0, 3'd5, 8'hA5, 8'h0F, 8'h55, 1'b0};
        vecs[6] = '{1'b1, 3'd4, 8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 3'd3, 8'h00, 8'h00, 8'hFF, 1'b0};
        vecs[8] = '{1'b1, 3'd7, 8'h12, 8'h34, 8'h00, 1'b1};
        vecs[9] = '{1'b0, 3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1};

        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // Single op with cycle-exact latency
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hF0; req0_b = 8'h3C;
        @(negedge clk);
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        sbq.push_back('{8'h30, 1'b0, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_a = 8'hFF; req0_b = 8'hFF;
        @(negedge clk);
        chk("exec_res_valid", res_valid, 0);
        chk("exec_busy", busy, 1);
        chk("exec_ready0", req0_ready, 0);
        @(negedge clk);
        chk("done_res_valid", res_valid, 1);
        chk("done_res_data", res_data, 8'h30);
        wait_drain();

        // Op sweep and illegal opcodes
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i]);
            wait_drain();
        end

        // Tie + fairness from a fresh reset
        do_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'hC3; req0_b = 8'hF0;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 8'hC3; req1_b = 8'hF0;
        grants = 0; cyc = 0; last_cyc = 0;
        for (int n = 0; n < 40 && grants < 4; n++) begin
            @(negedge clk);
            cyc++;
            if (req0_ready || req1_ready) begin
                gid = req1_ready;
                chk("tie_grant", gid, grants % 2);
                if (grants > 0) chk("tie_gap", cyc - last_cyc, 3);
                last_cyc = cyc;
                sbq.push_back(gid ? model(1'b1, req1_op, req1_a, req1_b)
                                  : model(1'b0, req0_op, req0_a, req0_b));
                grants++;
            end
        end
        chk("tie_count", grants, 4);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();

        // Back-pressure in DONE
        @(posedge clk); #1 res_ready = 1'b0;
        do_op('{1'b0, 3'd2, 8'h5A, 8'h81, 8'hDB, 1'b0});
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("bp_res_valid_seen", seen, 1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h0F; req0_b = 8'hF0;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 8'h3C; req1_b = 8'h3C;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 8'hDB);
            chk("bp_id", res_id, 0);
            chk("bp_err", res_err, 0);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drop_valid", res_valid, 0);
        chk("bp_next_ready1", req1_ready, 1);
        chk("bp_next_ready0", req0_ready, 0);
        sbq.push_back(model(1'b1, req1_op, req1_a, req1_b));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();

        // Reset while EXEC: result dropped, arbitration restarts at req0
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22;
        @(negedge clk);
        chk("mid_ready0", req0_ready, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_valid", res_valid, 0);
            chk("mid_idle", busy, 0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 8'h01; req0_b = 8'h80;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'hFF; req1_b = 8'hFF;
        @(negedge clk);
        chk("post_rst_tie0", req0_ready, 1);
        chk("post_rst_tie1", req1_ready, 0);
        sbq.push_back('{8'h81, 1'b0, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();

        chk("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
